md5_pad_block: RTL and testbench

MD5_PAD_BLOCK -- requirements
Module: md5_pad_block

---
 rtl/md5_pad_if.sv | 41 ++++
 rtl/md5_pad_block.sv | 194 +++++++++++++++++++
 tb/tb_md5_pad_block.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/md5_pad_if.sv
// md5_pad_if: groups the message-input stream, the padded-block output stream
// and the busy flag of md5_pad_block into one bundle.
//
//   in_data[31:0]      message word, byte 0 in [7:0]
//   in_valid           in_data valid
//   in_last            final message word
//   in_bytes[2:0]      valid bytes in the final word (0..4)
//   in_ready           word accepted when in_valid & in_ready
//   out_data[31:0]     padded block word
//   out_valid          out_data valid
//   out_ready          downstream accepts
//   out_word_idx[3:0]  word index within the 64-byte block
//   out_block_last     high on word 15 of the final block
//   busy               message in progress
//
// Modports:
//   slave  - the padding block (consumes the message stream, sources blocks)
//   master - the environment (sources the message stream, sinks blocks)
interface md5_pad_if;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [2:0]  in_bytes;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_word_idx;
    logic        out_block_last;
    logic        busy;

    modport slave (
        input  in_data, in_valid, in_last, in_bytes, out_ready,
        output in_ready, out_data, out_valid, out_word_idx, out_block_last, busy
    );

    modport master (
        output in_data, in_valid, in_last, in_bytes, out_ready,
        input  in_ready, out_data, out_valid, out_word_idx, out_block_last, busy
    );
endinterface

// File: rtl/md5_pad_block.sv
// md5_pad_block: applies MD5 message padding to a stream of 32-bit message
// words and emits the padded 512-bit blocks as 16 words each. After the last
// message byte a 0x80 marker is placed, zero words fill the block up to word
// 13, and the 64-bit message bit length follows at words 14 (low) and 15
// (high). If the marker lands at word 14 or 15 an extra all-zero block
// (apart from the length) is produced.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    md5_pad_if.slave: message input stream, block output stream, busy
//
// Optional feature: define MD5_PAD_BYTE_SWAP_EN to treat in_data[31:24] as
// message byte 0 (input words are byte-reversed before use; in_bytes then
// counts from the top byte). Output and length words are never swapped.
module md5_pad_block (
    input  logic      clk,
    input  logic      reset,
    md5_pad_if.slave  bus
);

    typedef enum logic [1:0] {DATA, PAD_ZERO, LEN_LO, LEN_HI} state_t;

    state_t       state, state_nxt;
    logic         pad80, pad80_nxt;   // first PAD_ZERO word carries the 0x80 marker
    logic [60:0]  byte_cnt;
    logic [3:0]   idx;                // index of the next word loaded into the output
    logic [31:0]  word_in;
    logic [2:0]   nlast;
    logic         can_load, in_fire, out_fire;
    logic         load, load_last;
    logic [31:0]  load_data;
    logic [2:0]   cnt_add;

    // Keep only bytes below n of a partial final word.
    function automatic logic [31:0] keep_mask(input logic [1:0] n);
        logic [31:0] m;
        case (n)
            2'd0:    m = 32'h0000_0000;
            2'd1:    m = 32'h0000_00FF;
            2'd2:    m = 32'h0000_FFFF;
            default: m = 32'h00FF_FFFF;
        endcase
        return m;
    endfunction

    // 0x80 marker placed in byte lane n.
    function automatic logic [31:0] pad_marker(input logic [1:0] n);
        return 32'h0000_0080 << {n, 3'b000};
    endfunction

`ifdef MD5_PAD_BYTE_SWAP_EN
    function automatic logic [31:0] byte_rev(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    assign word_in = byte_rev(bus.in_data);
`else
    assign word_in = bus.in_data;
`endif

    // Any count above 4 means a full final word.
    assign nlast = (bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes;

    // Output register may be (re)loaded when empty or being drained this cycle.
    assign can_load     = !bus.out_valid || bus.out_ready;
    assign bus.in_ready = (state == DATA) && can_load;
    assign in_fire      = bus.in_valid && bus.in_ready;
    assign out_fire     = bus.out_valid && bus.out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DATA;
            pad80 <= 1'b0;
        end else begin
            state <= state_nxt;
            pad80 <= pad80_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        pad80_nxt = pad80;
        unique case (state)
            DATA: begin
                if (in_fire && bus.in_last) begin
                    if (nlast == 3'd4) begin
                        // Full final word: marker goes out as its own word next.
                        state_nxt = PAD_ZERO;
                        pad80_nxt = 1'b1;
                    end else if (idx == 4'd13) begin
                        state_nxt = LEN_LO;
                    end else begin
                        state_nxt = PAD_ZERO;
                    end
                end
            end
            PAD_ZERO: begin
                if (can_load) begin
                    pad80_nxt = 1'b0;
                    // idx wraps through 15->0, so markers at 14/15 yield an extra block.
                    if (idx == 4'd13) state_nxt = LEN_LO;
                end
            end
            LEN_LO: begin
                if (can_load) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                if (can_load) state_nxt = DATA;
            end
        endcase
    end

    // Output logic: value loaded into the output register this cycle
    always_comb begin
        load      = 1'b0;
        load_data = 32'h0;
        load_last = 1'b0;
        cnt_add   = 3'd0;
        unique case (state)
            DATA: begin
                if (in_fire) begin
                    load = 1'b1;
                    if (!bus.in_last || nlast == 3'd4) begin
                        load_data = word_in;
                        cnt_add   = 3'd4;
                    end else begin
                        load_data = (word_in & keep_mask(nlast[1:0])) | pad_marker(nlast[1:0]);
                        cnt_add   = nlast;
                    end
                end
            end
            PAD_ZERO: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = pad80 ? 32'h0000_0080 : 32'h0;
                end
            end
            LEN_LO: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = {byte_cnt[28:0], 3'b000};
                end
            end
            LEN_HI: begin
                if (can_load) begin
                    load      = 1'b1;
                    load_data = byte_cnt[60:29];
                    load_last = 1'b1;
                end
            end
        endcase
    end

    // Byte counter and word index
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt <= '0;
            idx      <= 4'd0;
        end else begin
            if (state == LEN_HI && load) byte_cnt <= '0;
            else if (in_fire)            byte_cnt <= byte_cnt + 61'(cnt_add);
            if (load) idx <= idx + 4'd1;
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid      <= 1'b0;
            bus.out_data       <= 32'h0;
            bus.out_word_idx   <= 4'd0;
            bus.out_block_last <= 1'b0;
        end else if (load) begin
            bus.out_valid      <= 1'b1;
            bus.out_data       <= load_data;
            bus.out_word_idx   <= idx;
            bus.out_block_last <= load_last;
        end else if (out_fire) begin
            bus.out_valid      <= 1'b0;
        end
    end

    // busy: a new message accepted in the same cycle the previous one
    // finishes keeps busy high.
    always_ff @(posedge clk) begin
        if (reset)                              bus.busy <= 1'b0;
        else if (in_fire)                       bus.busy <= 1'b1;
        else if (out_fire && bus.out_block_last) bus.busy <= 1'b0;
    end

endmodule

// File: tb/tb_md5_pad_block.sv
// tb_md5_pad_block: directed bench for md5_pad_block. Expected output words
// come from a byte-level MD5 padding model (append 0x80, zero-fill to 56 mod
// 64, append little-endian 64-bit bit length, then split into words).
module tb_md5_pad_block;

    logic clk;
    logic reset;

    md5_pad_if bus ();

    md5_pad_block dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] d;
        logic [3:0]  i;
        logic        l;
    } exp_t;

    exp_t        sb[$];
    exp_t        exp_tmp[$];
    logic [7:0]  msg[$];

    int tests = 0;
    int fails = 0;

    int bp_mode  = 0;   // 0: always ready, 1: 5-cycle stall window, 2: random
    int cyc      = 0;
    int stall_st = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference padding: works on whole bytes, not on the block's word states.
    task automatic build_exp();
        logic [7:0]  p[$];
        logic [63:0] bits;
        int          nw;
        exp_t        e;
        p = msg;
        bits = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        for (int k = 0; k < 8; k++) p.push_back(bits[8*k +: 8]);
        nw = p.size() / 4;
        exp_tmp.delete();
        for (int k = 0; k < nw; k++) begin
            e.d = {p[4*k+3], p[4*k+2], p[4*k+1], p[4*k]};
            e.i = 4'(k % 16);
            e.l = (k == nw - 1);
            exp_tmp.push_back(e);
        end
    endtask

    task automatic make_msg(input int n, input int seed);
        msg.delete();
        for (int j = 0; j < n; j++) msg.push_back(8'(j * 37 + seed));
    endtask

    // Queue expectations for msg and drive its words; bytes_ovr >= 0 replaces
    // in_bytes on the final word.
    task automatic run_msg(input int bytes_ovr);
        int          nbytes, nw, n, g;
        logic [31:0] w;
        logic        ok;
        build_exp();
        foreach (exp_tmp[k]) sb.push_back(exp_tmp[k]);
        nbytes = msg.size();
        nw = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
        for (int wi = 0; wi < nw; wi++) begin
            n = (wi == nw - 1) ? nbytes - 4 * wi : 4;
            w = 32'h0;
            for (int b = 0; b < 4; b++)
                w[8*b +: 8] = (b < n) ? msg[4*wi + b] : 8'(8'hA5 + b);
`ifdef MD5_PAD_BYTE_SWAP_EN
            w = {w[7:0], w[15:8], w[23:16], w[31:24]};
`endif
            bus.in_data  = w;
            bus.in_valid = 1'b1;
            bus.in_last  = (wi == nw - 1);
            bus.in_bytes = (wi == nw - 1 && bytes_ovr >= 0) ? 3'(bytes_ovr) : 3'(n);
            g = 0;
            ok = 1'b0;
            while (!ok && g < 1000) begin
                @(negedge clk);
                ok = bus.in_ready;
                @(posedge clk);
                #1;
                g++;
            end
            if (!ok) chk("in_accept_timeout", 64'd0, 64'd1);
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int g;
        g = 0;
        while (sb.size() != 0 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (sb.size() != 0) chk({name, "_timeout"}, 64'(sb.size()), 64'd0);
        @(negedge clk);
        chk({name, "_busy_end"}, 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    // out_ready generator
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (bp_mode)
                1:       bus.out_ready = !(cyc >= stall_st && cyc < stall_st + 5);
                2:       bus.out_ready = ($urandom_range(0, 3) != 0);
                default: bus.out_ready = 1'b1;
            endcase
        end
    end

    // Compare process: scoreboard on every output handshake, hold/in_ready
    // checks on every stalled cycle.
    logic        stalled = 1'b0;
    logic [31:0] h_data;
    logic [3:0]  h_idx;
    logic        h_last;
    exp_t        e_c;

    always @(negedge clk) begin
        if (reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("hold", {bus.out_valid, bus.out_block_last, bus.out_word_idx, bus.out_data},
                    {1'b1, h_last, h_idx, h_data});
            if (bus.out_valid && !bus.out_ready) begin
                chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
                stalled = 1'b1;
                h_data  = bus.out_data;
                h_idx   = bus.out_word_idx;
                h_last  = bus.out_block_last;
            end else begin
                stalled = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {bus.out_word_idx, bus.out_data}, 64'd0);
                end else begin
                    e_c = sb.pop_front();
                    chk("out_word", {bus.out_block_last, bus.out_word_idx, bus.out_data},
                        {e_c.l, e_c.i, e_c.d});
                end
            end
        end
    end

    initial begin
        int g;
        reset        = 1'b1;
        bus.in_data  = 32'h0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_bytes = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_data", 64'(bus.out_data), 64'd0);
        chk("rst_out_idx", 64'(bus.out_word_idx), 64'd0);
        chk("rst_block_last", 64'(bus.out_block_last), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Empty message
        msg.delete();
        build_exp();
        chk("empty_model_len", 64'(exp_tmp.size()), 64'd16);
        chk("empty_model_w0", 64'(exp_tmp[0].d), 64'h80);
        chk("empty_model_last15", 64'(exp_tmp[15].l), 64'd1);
        run_msg(-1);
        wait_done("empty");

        // "abc"
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        build_exp();
        chk("abc_model_w0", 64'(exp_tmp[0].d), 64'h80636261);
        chk("abc_model_w14", 64'(exp_tmp[14].d), 64'h18);
        run_msg(-1);
        wait_done("abc");

        // 55 bytes: marker in top byte of word 13
        make_msg(55, 3);
        build_exp();
        chk("b55_model_len", 64'(exp_tmp.size()), 64'd16);
        chk("b55_model_w13_top", 64'(exp_tmp[13].d[31:24]), 64'h80);
        chk("b55_model_w14", 64'(exp_tmp[14].d), 64'h1B8);
        run_msg(-1);
        wait_done("b55");

        // 56 bytes: two blocks
        make_msg(56, 9);
        build_exp();
        chk("b56_model_len", 64'(exp_tmp.size()), 64'd32);
        chk("b56_model_w14", 64'(exp_tmp[14].d), 64'h80);
        chk("b56_model_w15_last", 64'(exp_tmp[15].l), 64'd0);
        chk("b56_model_w30", 64'(exp_tmp[30].d), 64'h1C0);
        run_msg(-1);
        wait_done("b56");

        // Marker positions around the block boundary
        make_msg(52, 1);  run_msg(-1); wait_done("b52");
        make_msg(53, 2);  run_msg(-1); wait_done("b53");
        make_msg(57, 4);  run_msg(-1); wait_done("b57");
        make_msg(60, 5);  run_msg(-1); wait_done("b60");
        make_msg(64, 6);  run_msg(-1); wait_done("b64");
        make_msg(1, 7);   run_msg(-1); wait_done("b1");

        // in_bytes above 4 on the final word counts as 4
        make_msg(8, 11);  run_msg(7);  wait_done("ovr7");

        // Back-to-back messages with random backpressure
        bp_mode = 2;
        make_msg(3, 13);  run_msg(-1);
        make_msg(70, 17); run_msg(-1);
        make_msg(6, 19);  run_msg(-1);
        wait_done("b2b");

        // 5-cycle stall mid-stream
        bp_mode  = 1;
        stall_st = cyc + 6;
        make_msg(40, 21); run_msg(-1);
        wait_done("stall");
        bp_mode = 0;

        // Reset during PAD_ZERO
        msg.delete();
        msg.push_back(8'h61); msg.push_back(8'h62); msg.push_back(8'h63);
        run_msg(-1);
        g = 0;
        do begin
            @(negedge clk);
            g++;
        end while (!(bus.out_valid && bus.out_word_idx == 4'd5) && g < 200);
        chk("pad_in_ready", 64'(bus.in_ready), 64'd0);
        chk("pad_busy", 64'(bus.busy), 64'd1);
        #1;
        reset = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("postrst_out_valid", 64'(bus.out_valid), 64'd0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        run_msg(-1);
        wait_done("abc_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
